vga_sync_gen: RTL and testbench

//   Timing generator for 640x480@60 Hz VGA. Sits directly upstream of the

---
 rtl/vga_sync_gen.sv | 104 ++++++++++
 tb/tb_vga_sync_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - 640x480@60 VGA timing generator: pixel divider, h/v counters, syncs
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick
);
    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_DISPLAY + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC - 1;
    localparam int DIV_W    = $clog2(CLK_DIV);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic             r_video_on;
    logic             r_hsync;
    logic             r_vsync;

    logic             w_tick;
    logic             w_x_end;
    logic             w_y_end;
    logic [9:0]       w_x_next;
    logic [9:0]       w_y_next;

    assign w_tick  = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_x_end = (r_x == 10'(H_TOTAL - 1));
    assign w_y_end = (r_y == 10'(V_TOTAL - 1));

    // Next counter values; decodes are built from these so they line up with the counters
    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (w_tick) begin
            if (w_x_end) begin
                w_x_next = '0;
                w_y_next = w_y_end ? '0 : r_y + 10'd1;
            end else begin
                w_x_next = r_x + 10'd1;
            end
        end
    end

    // Pixel-rate divider: wraps at CLK_DIV-1, which is where the pixel enable sits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Horizontal/vertical counters advance only on the pixel enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            r_x <= w_x_next;
            r_y <= w_y_next;
        end
    end

    // Registered decodes from next counter values, zero skew against pixel_x/pixel_y
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_video_on <= 1'b0;
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
        end else begin
            r_video_on <= (w_x_next < 10'(H_DISPLAY)) && (w_y_next < 10'(V_DISPLAY));
            r_hsync    <= !((w_x_next >= 10'(HS_START)) && (w_x_next <= 10'(HS_END)));
            r_vsync    <= !((w_y_next >= 10'(VS_START)) && (w_y_next <= 10'(VS_END)));
        end
    end

    assign p_tick     = w_tick;
    assign pixel_x    = r_x;
    assign pixel_y    = r_y;
    assign video_on   = r_video_on;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign frame_tick = w_tick & w_x_end & w_y_end;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench for vga_sync_gen (full-size and scaled instances)
module tb_vga_sync_gen;
    logic       clk;
    logic       rst_a;
    logic       rst_b;

    logic       a_pt, a_von, a_hs, a_vs, a_ft;
    logic [9:0] a_x, a_y;
    logic       b_pt, b_von, b_hs, b_vs, b_ft;
    logic [9:0] b_x, b_y;

    int n_err = 0;
    int n_chk = 0;

    vga_sync_gen u_dut (
        .clk(clk), .rst(rst_a), .p_tick(a_pt), .pixel_x(a_x), .pixel_y(a_y),
        .video_on(a_von), .hsync(a_hs), .vsync(a_vs), .frame_tick(a_ft)
    );

    // Scaled timing: 16 x 12 totals, 2 clks per pixel, 384 clks per frame
    vga_sync_gen #(
        .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) u_small (
        .clk(clk), .rst(rst_b), .p_tick(b_pt), .pixel_x(b_x), .pixel_y(b_y),
        .video_on(b_von), .hsync(b_hs), .vsync(b_vs), .frame_tick(b_ft)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   edge_n;
        logic pt;
        int   x;
        int   y;
        logic von;
        logic hs;
        logic vs;
        logic ft;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Release rst_a and replay the post-reset table against the full-size instance
    task automatic release_and_table(input string tag);
        int e;
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        e = 0;
        for (int i = 0; i < 9; i++) begin
            while (e < vt[i].edge_n) begin
                step();
                e++;
            end
            chk($sformatf("%s_e%0d_ptick", tag, e), a_pt, vt[i].pt);
            chk($sformatf("%s_e%0d_x", tag, e), a_x, vt[i].x);
            chk($sformatf("%s_e%0d_y", tag, e), a_y, vt[i].y);
            chk($sformatf("%s_e%0d_von", tag, e), a_von, vt[i].von);
            chk($sformatf("%s_e%0d_hs", tag, e), a_hs, vt[i].hs);
            chk($sformatf("%s_e%0d_vs", tag, e), a_vs, vt[i].vs);
            chk($sformatf("%s_e%0d_ft", tag, e), a_ft, vt[i].ft);
        end
    endtask

    initial begin
        int  cnt, cnt2, bad, xmin, xmax, first_ft, last_ft, n_ft;
        int  von_cnt, vs_cnt, hs_cnt, ivl_bad;
        bit  found, prev_ft;

        vt[0] = '{0,  1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[1] = '{1,  1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[2] = '{3,  1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[3] = '{4,  1'b0, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[4] = '{7,  1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[5] = '{8,  1'b0, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[6] = '{11, 1'b1, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[7] = '{12, 1'b0, 3, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[8] = '{13, 1'b0, 3, 0, 1'b1, 1'b1, 1'b1, 1'b0};

        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) step();

        // Reset state, then the first few pixel enables after release
        release_and_table("rel1");

        // Run to end of line 10 and check the line wrap
        found = 1'b0;
        for (int i = 0; i < 40000 && !found; i++) begin
            if (a_pt && a_x == 10'd799 && a_y == 10'd10) found = 1'b1;
            else step();
        end
        chk("reach_799_10", int'(found), 1);
        chk("end_line_hs", a_hs, 1);
        chk("end_line_von", a_von, 0);
        step();
        chk("wrap_x", a_x, 0);
        chk("wrap_y", a_y, 11);
        chk("wrap_ptick", a_pt, 0);
        chk("wrap_von", a_von, 1);
        cnt = 0;
        repeat (3) begin
            step();
            if (a_pt) cnt++;
        end
        chk("wrap_ptick_count", cnt, 1);

        // One whole line: hsync window, per-cycle decode alignment
        cnt = 0; cnt2 = 0; bad = 0; xmin = 1023; xmax = -1;
        for (int i = 0; i < 3200; i++) begin
            step();
            if (a_hs !== !(a_x >= 656 && a_x <= 751)) bad++;
            if (a_von !== (a_x < 640 && a_y < 480)) bad++;
            if (a_vs !== 1'b1) bad++;
            if (!a_hs) begin
                cnt2++;
                if (a_pt) cnt++;
                if (int'(a_x) < xmin) xmin = a_x;
                if (int'(a_x) > xmax) xmax = a_x;
            end
        end
        chk("line_hs_pticks", cnt, 96);
        chk("line_hs_clks", cnt2, 384);
        chk("line_hs_first_x", xmin, 656);
        chk("line_hs_last_x", xmax, 751);
        chk("line_decode_bad", bad, 0);
        chk("line_end_y", a_y, 12);
        chk("line_end_x", a_x, 0);

        // Asynchronous reset mid-line, mid-divider
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            if (a_pt && a_x == 10'd300) found = 1'b1;
            else step();
        end
        chk("reach_300", int'(found), 1);
        step();
        step();
        chk("pre_rst_x", a_x, 301);
        #2;
        rst_a = 1'b0;
        #1;
        chk("arst_x", a_x, 0);
        chk("arst_y", a_y, 0);
        chk("arst_hs", a_hs, 1);
        chk("arst_vs", a_vs, 1);
        chk("arst_von", a_von, 0);
        chk("arst_ptick", a_pt, 0);
        step();
        step();
        chk("arst_hold_x", a_x, 0);
        release_and_table("rel2");

        // Scaled instance: three whole frames
        @(negedge clk);
        rst_b = 1'b1;
        bad = 0; n_ft = 0; first_ft = -1; last_ft = -1; ivl_bad = 0;
        von_cnt = 0; vs_cnt = 0; hs_cnt = 0; prev_ft = 1'b0;
        for (int e = 1; e <= 1152; e++) begin
            step();
            if (b_hs !== !(b_x >= 10 && b_x <= 12)) bad++;
            if (b_vs !== !(b_y >= 8 && b_y <= 9)) bad++;
            if (b_von !== (b_x < 8 && b_y < 6)) bad++;
            if (prev_ft && (b_x != 0 || b_y != 0)) bad++;
            if (e <= 384 && b_pt) begin
                if (b_von) von_cnt++;
                if (!b_vs) vs_cnt++;
                if (!b_hs) hs_cnt++;
            end
            prev_ft = b_ft;
            if (b_ft) begin
                if (b_x != 15 || b_y != 11 || !b_pt) bad++;
                if (first_ft < 0) first_ft = e;
                if (last_ft >= 0 && e - last_ft != 384) ivl_bad++;
                last_ft = e;
                n_ft++;
            end
        end
        chk("frame_decode_bad", bad, 0);
        chk("frame_first_ft", first_ft, 383);
        chk("frame_ft_count", n_ft, 3);
        chk("frame_ft_interval", ivl_bad, 0);
        chk("frame_von_pticks", von_cnt, 48);
        chk("frame_vs_pticks", vs_cnt, 32);
        chk("frame_hs_pticks", hs_cnt, 36);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
